mul_seq_ctrl: RTL and testbench



---
 rtl/mul_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Digit-serial OP_W x OP_W unsigned multiply sequencer driving one shared 3x3 multiplier.
// Optional MUL_SEQ_BACK_TO_BACK_EN lets a new operand pair be accepted on the result handshake edge.
module mul_seq_ctrl #(
    parameter int OP_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic [2:0]        mul_a,
    output logic [2:0]        mul_b,
    input  logic [5:0]        mul_s,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] out_p,
    output logic              busy
);

    localparam int K     = OP_W / 3;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int ACC_W = 2 * OP_W;
    localparam int SH_W  = $clog2(ACC_W) + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [2:0]         mul_a_q, mul_a_d;
    logic [2:0]         mul_b_q, mul_b_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_p_q, out_p_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               last_i, last_j;
    logic [IDX_W-1:0]   i_nxt, j_nxt;
    logic [SH_W-1:0]    sh_amt;
    logic [ACC_W-1:0]   acc_sum;

    function automatic logic [2:0] digit(input logic [OP_W-1:0] v, input logic [IDX_W-1:0] idx);
        logic [OP_W-1:0] s;
        s = v >> (SH_W'(idx) * SH_W'(3));
        return s[2:0];
    endfunction

`ifdef MUL_SEQ_BACK_TO_BACK_EN
    assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
`else
    assign in_ready = rst_n & (state_q == IDLE);
`endif

    assign accept  = in_valid & in_ready;
    assign last_i  = (i_q == IDX_W'(K - 1));
    assign last_j  = (j_q == IDX_W'(K - 1));
    assign i_nxt   = last_j ? (i_q + IDX_W'(1)) : i_q;
    assign j_nxt   = last_j ? '0 : (j_q + IDX_W'(1));
    // partial product weight is 8^(i+j)
    assign sh_amt  = (SH_W'(i_q) + SH_W'(j_q)) * SH_W'(3);
    assign acc_sum = acc_q + (ACC_W'(mul_s) << sh_amt);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        busy_d      = busy_q;

        case (state_q)
            RUN: begin
                acc_d = acc_sum;
                i_d   = i_nxt;
                j_d   = j_nxt;
                if (last_i && last_j) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_p_d     = acc_sum;
                    mul_a_d     = '0;
                    mul_b_d     = '0;
                end else begin
                    mul_a_d = digit(a_q, i_nxt);
                    mul_b_d = digit(b_q, j_nxt);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase

        // overrides the DONE exit when a new pair arrives on the handshake edge
        if (accept) begin
            state_d = RUN;
            a_d     = in_a;
            b_d     = in_b;
            i_d     = '0;
            j_d     = '0;
            acc_d   = '0;
            mul_a_d = in_a[2:0];
            mul_b_d = in_b[2:0];
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: OP_W=6 and OP_W=9 instances, each fed by a behavioural 3x3 multiplier.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [5:0]  in_a, in_b;
    logic [2:0]  mul_a, mul_b;
    logic [5:0]  mul_s;
    logic        out_valid, out_ready;
    logic [11:0] out_p;
    logic        busy;

    logic        in_valid9, in_ready9;
    logic [8:0]  in_a9, in_b9;
    logic [2:0]  mul_a9, mul_b9;
    logic [5:0]  mul_s9;
    logic        out_valid9, out_ready9;
    logic [17:0] out_p9;
    logic        busy9;

    int chk_cnt = 0;
    int pass_cnt = 0;

    assign mul_s  = mul_a * mul_b;
    assign mul_s9 = mul_a9 * mul_b9;

    mul_seq_ctrl #(.OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
    );

    mul_seq_ctrl #(.OP_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid9), .in_ready(in_ready9), .in_a(in_a9), .in_b(in_b9),
        .mul_a(mul_a9), .mul_b(mul_b9), .mul_s(mul_s9),
        .out_valid(out_valid9), .out_ready(out_ready9), .out_p(out_p9), .busy(busy9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    // Called at the negedge following the accept edge; returns edges until out_valid.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic issue(input logic [5:0] a, input logic [5:0] b);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %0b want 0", in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_valid_busy: got %0b/%0b want 0/0", out_valid, busy);
        else pass_cnt++;
        chk_cnt++;
        if (out_p !== 12'd0 || mul_a !== 3'd0 || mul_b !== 3'd0)
            $display("FAIL reset_outputs: got p=%0d a=%0d b=%0d want 0", out_p, mul_a, mul_b);
        else pass_cnt++;
        chk_cnt++;
        if (out_p9 !== 18'd0 || in_ready9 !== 1'b1)
            $display("FAIL reset_w9: got p=%0d rdy=%0b want 0/1", out_p9, in_ready9);
        else pass_cnt++;
    endtask

    task automatic test_max;
        int cyc;
        issue(6'd63, 6'd63);
        in_a = 6'd0;
        in_b = 6'd0;
        for (int c = 0; c < 4; c++) begin
            chk_cnt++;
            if (mul_a !== 3'd7 || mul_b !== 3'd7 || out_valid !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL max_run_cycle%0d: got a=%0d b=%0d v=%0b rdy=%0b want 7 7 0 0",
                         c, mul_a, mul_b, out_valid, in_ready);
            else pass_cnt++;
            @(negedge clk);
        end
        chk_cnt++;
        if (out_valid !== 1'b1 || out_p !== 12'd3969)
            $display("FAIL max_result: got v=%0b p=%0d want 1 3969", out_valid, out_p);
        else pass_cnt++;
        chk_cnt++;
        if (mul_a !== 3'd0 || mul_b !== 3'd0 || busy !== 1'b1)
            $display("FAIL max_done_outputs: got a=%0d b=%0d busy=%0b want 0 0 1", mul_a, mul_b, busy);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_p !== 12'd3969)
            $display("FAIL max_after_hs: got v=%0b rdy=%0b busy=%0b p=%0d want 0 1 0 3969",
                     out_valid, in_ready, busy, out_p);
        else pass_cnt++;
        cyc = 0;
    endtask

    task automatic test_small;
        int cyc;
        issue(6'd5, 6'd7);
        wait_valid(cyc);
        chk_cnt++;
        if (out_p !== 12'd35 || cyc != 4)
            $display("FAIL small_5x7: got p=%0d lat=%0d want 35 4", out_p, cyc);
        else pass_cnt++;
        @(negedge clk);
        issue(6'd0, 6'd42);
        wait_valid(cyc);
        chk_cnt++;
        if (out_p !== 12'd0 || cyc != 4)
            $display("FAIL small_0x42: got p=%0d lat=%0d want 0 4", out_p, cyc);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_stall;
        int cyc;
        out_ready = 1'b0;
        issue(6'd45, 6'd27);
        wait_valid(cyc);
        in_a = 6'd1;
        in_b = 6'd1;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk_cnt++;
            if (out_valid !== 1'b1 || out_p !== 12'd1215 || in_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL stall_hold%0d: got v=%0b p=%0d rdy=%0b busy=%0b want 1 1215 0 1",
                         c, out_valid, out_p, in_ready, busy);
            else pass_cnt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
`ifdef MUL_SEQ_BACK_TO_BACK_EN
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || mul_a !== 3'd1)
            $display("FAIL stall_release_b2b: got v=%0b busy=%0b a=%0d want 0 1 1", out_valid, busy, mul_a);
        else pass_cnt++;
        in_valid = 1'b0;
`else
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stall_release: got v=%0b busy=%0b rdy=%0b want 0 0 1", out_valid, busy, in_ready);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
`endif
        wait_valid(cyc);
        chk_cnt++;
        if (out_p !== 12'd1 || out_valid !== 1'b1)
            $display("FAIL stall_queued_1x1: got p=%0d v=%0b want 1 1", out_p, out_valid);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        int cyc;
        issue(6'd63, 6'd63);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || mul_a !== 3'd0 || mul_b !== 3'd0 || out_p !== 12'd0)
            $display("FAIL midreset_async: got v=%0b busy=%0b a=%0d b=%0d p=%0d want all 0",
                     out_valid, busy, mul_a, mul_b, out_p);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_cnt++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL midreset_idle%0d: got v=%0b rdy=%0b want 0 1", c, out_valid, in_ready);
            else pass_cnt++;
        end
        issue(6'd3, 6'd3);
        wait_valid(cyc);
        chk_cnt++;
        if (out_p !== 12'd9 || cyc != 4)
            $display("FAIL midreset_3x3: got p=%0d lat=%0d want 9 4", out_p, cyc);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_wide;
        int cyc;
        int run_cnt;
        in_a9 = 9'd511;
        in_b9 = 9'd511;
        in_valid9 = 1'b1;
        @(negedge clk);
        in_valid9 = 1'b0;
        cyc = 0;
        run_cnt = 0;
        while (out_valid9 !== 1'b1 && cyc < 40) begin
            if (mul_a9 === 3'd7 && mul_b9 === 3'd7) run_cnt++;
            @(negedge clk);
            cyc++;
        end
        chk_cnt++;
        if (cyc != 9 || run_cnt != 9)
            $display("FAIL wide_latency: got lat=%0d run=%0d want 9 9", cyc, run_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (out_p9 !== 18'd261121)
            $display("FAIL wide_511x511: got %0d want 261121", out_p9);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (out_valid9 !== 1'b0 || in_ready9 !== 1'b1)
            $display("FAIL wide_after_hs: got v=%0b rdy=%0b want 0 1", out_valid9, in_ready9);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int cyc;
        int gap;
        in_a = 6'd12;
        in_b = 6'd10;
        in_valid = 1'b1;
        @(negedge clk);
        in_a = 6'd33;
        in_b = 6'd2;
        wait_valid(cyc);
        chk_cnt++;
        if (out_p !== 12'd120 || cyc != 4)
            $display("FAIL b2b_first: got p=%0d lat=%0d want 120 4", out_p, cyc);
        else pass_cnt++;
`ifdef MUL_SEQ_BACK_TO_BACK_EN
        chk_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL b2b_ready_in_done: got %0b want 1", in_ready);
        else pass_cnt++;
`else
        chk_cnt++;
        if (in_ready !== 1'b0)
            $display("FAIL b2b_ready_in_done: got %0b want 0", in_ready);
        else pass_cnt++;
`endif
        @(negedge clk);
        gap = 1;
        while (out_valid !== 1'b1 && gap < 30) begin
            if (busy === 1'b1) in_valid = 1'b0;
            @(negedge clk);
            gap++;
        end
        in_valid = 1'b0;
`ifdef MUL_SEQ_BACK_TO_BACK_EN
        chk_cnt++;
        if (gap != 5) $display("FAIL b2b_gap: got %0d want 5", gap);
        else pass_cnt++;
`else
        chk_cnt++;
        if (gap != 6) $display("FAIL b2b_gap: got %0d want 6", gap);
        else pass_cnt++;
`endif
        chk_cnt++;
        if (out_p !== 12'd66)
            $display("FAIL b2b_second: got %0d want 66", out_p);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        in_valid9 = 1'b0;
        in_a9 = '0;
        in_b9 = '0;
        out_ready9 = 1'b1;
        @(negedge clk);
        test_reset;
        test_max;
        test_small;
        test_stall;
        test_mid_reset;
        test_wide;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
